// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet framing path.
// Imported by the framing controller and its timeout timer.
package ps2_pkg;

    localparam int PS2_SYNC_BIT  = 3;
    localparam int PS2_PKT_BYTES = 3;
    localparam int PS2_PKT_W     = PS2_PKT_BYTES * 8;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2,
        FULL = 2'd3
    } ps2_state_e;

    // byte1 lands in the most significant byte when the struct is flattened
    typedef struct packed {
        logic [7:0] byte1;
        logic [7:0] byte2;
        logic [7:0] byte3;
    } ps2_packet_t;

    // True when a byte carries the packet sync marker
    function automatic logic is_sync_byte(input logic [7:0] b);
        return b[PS2_SYNC_BIT];
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Inter-byte timeout down-counter: reloads on clear, counts while run is high,
// and flags expire during the cycle in which the TIMEOUT_CYCLES-th idle cycle ends.
module ps2_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ZERO_VAL = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Down-counter holding the idle cycles left before expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= LOAD_VAL;
        end else if (clear) begin
            cnt_r <= LOAD_VAL;
        end else if (run && (cnt_r != ZERO_VAL)) begin
            cnt_r <= cnt_r - ONE_VAL;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = run && (cnt_r == ZERO_VAL);

endmodule

// File: rtl/ps2_packet_ctrl.sv
// Frames a PS/2 byte stream into 3-byte mouse packets with sync-bit alignment,
// inter-byte timeout resynchronisation and a saturating drop counter.
module ps2_packet_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DROP_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PS2_PKT_W-1:0] out_packet,
    input  logic                 out_ready,
    output logic                 timeout,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    ps2_state_e        state_r;
    ps2_packet_t       pkt_r;
    logic [DROP_W-1:0] drop_r;
    logic              timeout_r;
    logic              in_ready_r;
    logic              out_valid_r;

    logic accept_s;
    logic timer_run_s;
    logic timer_clear_s;
    logic timer_expire_s;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : (v + DROP_ONE);
    endfunction

    assign accept_s      = in_valid && in_ready_r;
    assign timer_run_s   = (state_r == GOT1) || (state_r == GOT2);
    // Holding clear outside GOT1/GOT2 reloads the timer on entry to SYNC or FULL
    assign timer_clear_s = accept_s || !timer_run_s;

    ps2_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .run    (timer_run_s),
        .expire (timer_expire_s)
    );

    // Framing FSM with byte capture, drop accounting and registered handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= SYNC;
            pkt_r       <= '0;
            drop_r      <= '0;
            timeout_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                SYNC: begin
                    if (accept_s && enable && is_sync_byte(in_data)) begin
                        pkt_r.byte1 <= in_data;
                        state_r     <= GOT1;
                    end else if (accept_s && enable) begin
                        drop_r <= sat_inc(drop_r);
                    end else begin
                        state_r <= SYNC;
                    end
                end
                GOT1: begin
                    // Disable outranks both a new byte and a pending expiry
                    if (!enable) begin
                        state_r <= SYNC;
                    end else if (accept_s) begin
                        pkt_r.byte2 <= in_data;
                        state_r     <= GOT2;
                    end else if (timer_expire_s) begin
                        state_r   <= SYNC;
                        timeout_r <= 1'b1;
                        drop_r    <= sat_inc(drop_r);
                    end else begin
                        state_r <= GOT1;
                    end
                end
                GOT2: begin
                    if (!enable) begin
                        state_r <= SYNC;
                    end else if (accept_s) begin
                        pkt_r.byte3 <= in_data;
                        state_r     <= FULL;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else if (timer_expire_s) begin
                        state_r   <= SYNC;
                        timeout_r <= 1'b1;
                        drop_r    <= sat_inc(drop_r);
                    end else begin
                        state_r <= GOT2;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_r     <= SYNC;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r     <= SYNC;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_packet = pkt_r;
    assign timeout    = timeout_r;
    assign drop_cnt   = drop_r;

endmodule
